// File: rtl/traffic_light_monitor.sv
// traffic_light_monitor: passive checker for the one-hot {red, yellow, green}
// lamp bus. Re-decodes the phase, measures dwell, flags bad codes,
// out-of-order transitions and dwell violations, and counts light cycles.
module traffic_light_monitor #(
  parameter int unsigned MIN_DWELL = 16,
  parameter int unsigned MAX_DWELL = 16
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [2:0] i_light,
  input  logic       i_clr,
  output logic [1:0] o_phase,
  output logic [7:0] o_phase_len,
  output logic       o_len_valid,
  output logic       o_err_code,
  output logic       o_err_seq,
  output logic       o_err_dur,
  output logic [2:0] o_err_sticky,
  output logic [7:0] o_cycle_count,
  output logic       o_locked
);

  localparam int unsigned LW = 3;
  localparam int unsigned PW = 2;
  localparam int unsigned DW = 8;

  localparam logic [DW-1:0] MIN_L   = DW'(MIN_DWELL);
  localparam logic [DW-1:0] MAX_L   = DW'(MAX_DWELL);
  localparam logic [DW-1:0] DW_SAT  = '1;

  localparam logic [PW-1:0] PH_RED  = 2'b00;
  localparam logic [PW-1:0] PH_YEL  = 2'b01;
  localparam logic [PW-1:0] PH_GRN  = 2'b10;
  localparam logic [PW-1:0] PH_UNK  = 2'b11;

  typedef enum logic {S_SYNC, S_TRACK} state_t;

  state_t        r_state, w_state_nx;
  logic [LW-1:0] r_light_q;
  logic          r_q_vld;
  logic [PW-1:0] r_phase, w_phase_nx;
  logic [DW-1:0] r_dwell, w_dwell_nx;
  logic          r_partial, w_partial_nx;
  logic [DW-1:0] r_phase_len, w_len_nx;
  logic          r_len_valid, w_len_valid_nx;
  logic          r_err_code, w_err_code_nx;
  logic          r_err_seq, w_err_seq_nx;
  logic          r_err_dur, w_err_dur_nx;
  logic [2:0]    r_err_sticky, w_sticky_nx;
  logic [DW-1:0] r_cycle_count, w_count_nx;
  logic          w_onehot;
  logic [PW-1:0] w_dec;
  logic          w_legal;
  logic          w_yr;

  // Decode the registered bus into a phase code and one-hot validity
  always_comb begin
    w_onehot = 1'b1;
    w_dec    = PH_UNK;
    case (r_light_q)
      3'b100:  w_dec = PH_RED;
      3'b010:  w_dec = PH_YEL;
      3'b001:  w_dec = PH_GRN;
      default: w_onehot = 1'b0;
    endcase
  end

  // Legal successor: RED->GREEN, GREEN->YELLOW, YELLOW->RED
  always_comb begin
    w_legal = ((r_phase == PH_RED) && (w_dec == PH_GRN)) ||
              ((r_phase == PH_GRN) && (w_dec == PH_YEL)) ||
              ((r_phase == PH_YEL) && (w_dec == PH_RED));
  end

  // Next state, dwell tracking and report generation
  always_comb begin
    w_state_nx     = r_state;
    w_phase_nx     = r_phase;
    w_dwell_nx     = r_dwell;
    w_partial_nx   = r_partial;
    w_len_nx       = r_phase_len;
    w_len_valid_nx = 1'b0;
    w_err_code_nx  = 1'b0;
    w_err_seq_nx   = 1'b0;
    w_err_dur_nx   = 1'b0;
    w_yr           = 1'b0;
    // The reset-cleared light_q is not a sampled code, so it is skipped
    if (r_q_vld) begin
      case (r_state)
        S_SYNC: begin
          if (w_onehot) begin
            w_phase_nx   = w_dec;
            w_dwell_nx   = DW'(1);
            w_partial_nx = 1'b1;
            w_state_nx   = S_TRACK;
          end else begin
            w_err_code_nx = 1'b1;
          end
        end
        S_TRACK: begin
          if (!w_onehot) begin
            w_err_code_nx = 1'b1;
            w_dwell_nx    = '0;
            w_phase_nx    = PH_UNK;
            w_state_nx    = S_SYNC;
          end else if (w_dec == r_phase) begin
            if (r_dwell != DW_SAT) w_dwell_nx = r_dwell + DW'(1);
          end else begin
            w_len_nx       = r_dwell;
            w_len_valid_nx = 1'b1;
            w_err_dur_nx   = !r_partial && ((r_dwell < MIN_L) || (r_dwell > MAX_L));
            w_err_seq_nx   = !w_legal;
            w_yr           = (r_phase == PH_YEL) && (w_dec == PH_RED);
            w_phase_nx     = w_dec;
            w_dwell_nx     = DW'(1);
            w_partial_nx   = 1'b0;
          end
        end
        default: w_state_nx = S_SYNC;
      endcase
    end
    // Clear first, then let same-cycle events win
    w_sticky_nx = (i_clr ? 3'b000 : r_err_sticky) |
                  {w_err_dur_nx, w_err_seq_nx, w_err_code_nx};
    w_count_nx  = (i_clr ? '0 : r_cycle_count) + DW'(w_yr);
  end

  // FSM state register
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= S_SYNC;
    else       r_state <= w_state_nx;
  end

  // Input capture and datapath/report registers
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_light_q     <= '0;
      r_q_vld       <= 1'b0;
      r_phase       <= PH_UNK;
      r_dwell       <= '0;
      r_partial     <= 1'b0;
      r_phase_len   <= '0;
      r_len_valid   <= 1'b0;
      r_err_code    <= 1'b0;
      r_err_seq     <= 1'b0;
      r_err_dur     <= 1'b0;
      r_err_sticky  <= '0;
      r_cycle_count <= '0;
    end else begin
      r_light_q     <= i_light;
      r_q_vld       <= 1'b1;
      r_phase       <= w_phase_nx;
      r_dwell       <= w_dwell_nx;
      r_partial     <= w_partial_nx;
      r_phase_len   <= w_len_nx;
      r_len_valid   <= w_len_valid_nx;
      r_err_code    <= w_err_code_nx;
      r_err_seq     <= w_err_seq_nx;
      r_err_dur     <= w_err_dur_nx;
      r_err_sticky  <= w_sticky_nx;
      r_cycle_count <= w_count_nx;
    end
  end

  assign o_phase       = r_phase;
  assign o_phase_len   = r_phase_len;
  assign o_len_valid   = r_len_valid;
  assign o_err_code    = r_err_code;
  assign o_err_seq     = r_err_seq;
  assign o_err_dur     = r_err_dur;
  assign o_err_sticky  = r_err_sticky;
  assign o_cycle_count = r_cycle_count;
  assign o_locked      = (r_state == S_TRACK);

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Scoreboard bench for traffic_light_monitor: a run-length reference model
// predicts every cycle's outputs plus each completed-phase report.
module tb_traffic_light_monitor;

  localparam int unsigned MIN_D = 16;
  localparam int unsigned MAX_D = 16;
  localparam logic [2:0] RED = 3'b100, YEL = 3'b010, GRN = 3'b001;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] light = 3'b000;
  logic       clr = 1'b0;
  logic [1:0] phase;
  logic [7:0] phase_len;
  logic       len_valid, err_code, err_seq, err_dur, locked;
  logic [2:0] err_sticky;
  logic [7:0] cycle_count;

  traffic_light_monitor #(.MIN_DWELL(MIN_D), .MAX_DWELL(MAX_D)) dut (
    .i_clk(clk), .i_rst(rst), .i_light(light), .i_clr(clr),
    .o_phase(phase), .o_phase_len(phase_len), .o_len_valid(len_valid),
    .o_err_code(err_code), .o_err_seq(err_seq), .o_err_dur(err_dur),
    .o_err_sticky(err_sticky), .o_cycle_count(cycle_count), .o_locked(locked)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] len;
    logic       dur;
    logic       seq;
  } ev_t;

  logic [25:0] exp_q[$];
  ev_t         ev_q[$];
  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: ring position R=0, G=1, Y=2; legal step is +1 mod 3
  bit         m_locked, m_first, m_pv;
  int         m_ring, m_run;
  logic [2:0] m_prev;
  logic [7:0] m_len, m_cnt;
  logic [2:0] m_sticky;

  function automatic int ring_of(input logic [2:0] c);
    if (c == RED) return 0;
    if (c == GRN) return 1;
    if (c == YEL) return 2;
    return -1;
  endfunction

  function automatic logic [1:0] phase_of(input int r);
    if (r == 0) return 2'b00;
    if (r == 1) return 2'b10;
    return 2'b01;
  endfunction

  task automatic model_reset();
    m_locked = 0; m_first = 0; m_pv = 0; m_ring = -1; m_run = 0;
    m_prev = 3'b000; m_len = 8'd0; m_cnt = 8'd0; m_sticky = 3'b000;
  endtask

  task automatic model_step(input logic [2:0] l, input bit c, input bit r);
    bit lv = 0, ec = 0, es = 0, ed = 0, yr = 0;
    int nr, len;
    if (r) begin
      model_reset();
    end else begin
      if (m_pv) begin
        nr = ring_of(m_prev);
        if (nr < 0) begin
          ec = 1;
          m_locked = 0;
          m_run = 0;
        end else if (!m_locked) begin
          m_locked = 1; m_ring = nr; m_run = 1; m_first = 1;
        end else if (nr == m_ring) begin
          m_run++;
        end else begin
          len = (m_run > 255) ? 255 : m_run;
          m_len = 8'(len);
          lv = 1;
          ed = !m_first && (len < int'(MIN_D) || len > int'(MAX_D));
          es = (nr != (m_ring + 1) % 3);
          yr = (m_ring == 2) && (nr == 0);
          m_ring = nr; m_run = 1; m_first = 0;
        end
      end
      m_prev = l;
      m_pv = 1;
      if (c) begin m_sticky = 3'b000; m_cnt = 8'd0; end
      m_sticky = m_sticky | {ed, es, ec};
      m_cnt = m_cnt + 8'(yr);
      if (lv) ev_q.push_back('{len: m_len, dur: ed, seq: es});
    end
    exp_q.push_back({(m_locked ? phase_of(m_ring) : 2'b11), m_len, lv, ec, es, ed,
                     m_sticky, m_cnt, m_locked});
  endtask

  // Drive one light code for n cycles (clr on every one of them if c)
  task automatic drive(input logic [2:0] l, input int n, input bit c);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      rst = 1'b0; light = l; clr = c;
      model_step(l, c, 1'b0);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; clr = 1'b0;
    model_step(light, 1'b0, 1'b1);
  endtask

  // Monitor: per-cycle status check, and a report check on each len_valid
  initial begin
    logic [25:0] e, a;
    ev_t ee, ae;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = {phase, phase_len, len_valid, err_code, err_seq, err_dur,
             err_sticky, cycle_count, locked};
        n_tests++;
        if (a !== e) begin
          n_fail++;
          $display("FAIL status t=%0t act ph=%b len=%0d lv=%b c/s/d=%b%b%b st=%b cnt=%0d lk=%b exp ph=%b len=%0d lv=%b c/s/d=%b%b%b st=%b cnt=%0d lk=%b",
                   $time, a[25:24], a[23:16], a[15], a[14], a[13], a[12], a[11:9], a[8:1], a[0],
                   e[25:24], e[23:16], e[15], e[14], e[13], e[12], e[11:9], e[8:1], e[0]);
        end
      end
      if (len_valid === 1'b1) begin
        n_tests++;
        ae = '{len: phase_len, dur: err_dur, seq: err_seq};
        if (ev_q.size() == 0) begin
          n_fail++;
          $display("FAIL report t=%0t unexpected len_valid len=%0d", $time, phase_len);
        end else begin
          ee = ev_q.pop_front();
          if (ae !== ee) begin
            n_fail++;
            $display("FAIL report t=%0t act len=%0d dur=%b seq=%b exp len=%0d dur=%b seq=%b",
                     $time, ae.len, ae.dur, ae.seq, ee.len, ee.dur, ee.seq);
          end
        end
      end
    end
  end

  // Stimulus: directed scenarios then randomized light traffic
  initial begin
    logic [2:0] bad [5];
    logic [2:0] code;
    int cur, nxt, r, len;
    bad[0] = 3'b000; bad[1] = 3'b011; bad[2] = 3'b110; bad[3] = 3'b101; bad[4] = 3'b111;
    model_reset();

    // Nominal sequence, two full cycles
    do_reset();
    drive(RED, 16, 0); drive(GRN, 16, 0); drive(YEL, 16, 0);
    drive(RED, 16, 0); drive(GRN, 16, 0); drive(YEL, 16, 0); drive(RED, 4, 0);
    // Illegal code mid-GREEN, then relock
    drive(RED, 12, 0); drive(GRN, 5, 0); drive(3'b110, 1, 0); drive(GRN, 5, 0);
    drive(YEL, 16, 0); drive(RED, 16, 0);
    // Sequence error RED->YELLOW
    drive(YEL, 16, 0); drive(RED, 16, 0); drive(GRN, 16, 0);
    // Duration errors: short and saturated GREEN
    drive(YEL, 16, 0); drive(RED, 16, 0); drive(GRN, 10, 0); drive(YEL, 16, 0);
    drive(RED, 16, 0); drive(GRN, 300, 0); drive(YEL, 16, 0);
    // clr coincident with an err_seq pulse
    drive(RED, 16, 0); drive(YEL, 1, 0); drive(YEL, 1, 1); drive(YEL, 14, 0);
    // clr coincident with a YELLOW->RED count
    drive(RED, 1, 0); drive(RED, 1, 1); drive(RED, 14, 0);
    // Reset mid-YELLOW, then re-sync with a partial first phase
    drive(GRN, 16, 0); drive(YEL, 8, 0); do_reset();
    drive(YEL, 5, 0); drive(RED, 16, 0); drive(GRN, 16, 0);
    // Back-to-back single-cycle phases
    drive(YEL, 1, 0); drive(RED, 1, 0); drive(GRN, 1, 0); drive(YEL, 1, 0);

    cur = 2;
    for (int s = 0; s < 120; s++) begin
      r = int'($urandom_range(0, 99));
      if (r < 3) begin
        do_reset();
        continue;
      end
      if (r < 12) begin
        drive(bad[$urandom_range(0, 4)], 1, 0);
        continue;
      end
      nxt = (r < 22) ? int'($urandom_range(0, 2)) : (cur + 1) % 3;
      code = (nxt == 0) ? RED : ((nxt == 1) ? GRN : YEL);
      len = ($urandom_range(0, 19) == 0) ? 270 :
            (($urandom_range(0, 1) == 0) ? 16 : int'($urandom_range(1, 24)));
      for (int i = 0; i < len; i++) drive(code, 1, ($urandom_range(0, 29) == 0));
      cur = nxt;
    end

    drive(RED, 3, 0);
    @(negedge clk);
    @(negedge clk);
    n_tests++;
    if (exp_q.size() != 0 || ev_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain act status=%0d reports=%0d left exp 0 0", exp_q.size(), ev_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
